rs_pipeline_sink_fifo: RTL and testbench

Receiving end of a feed-forward pipelined stream link. Upstream pushes words through `PIPELINE_LEVEL` stages of feed-forward registers that have no backpressure path. This block absorbs every word still in flight after it withdraws permission, and returns a registered `if_full_n` credit signal upstream through an equal number of feed-forward stages. Downstream sees an ordinary show-ahead FIFO read interface.

---
 rtl/rs_pipeline_sink_fifo_pkg.sv | 21 ++
 rtl/rs_sink_fifo_mem.sv | 42 ++++
 rtl/rs_pipeline_sink_fifo.sv | 98 +++++++++
 tb/tb_rs_pipeline_sink_fifo.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/rs_pipeline_sink_fifo_pkg.sv
// Shared arithmetic for the pipelined stream link. The transmit-side wrapper
// imports the same functions so both ends agree on headroom and widths.
package rs_pipeline_sink_fifo_pkg;

    // Writes that can still land after the credit drops: one pipeline's
    // worth for the credit to travel back, one for words already in flight.
    function automatic int headroom(input int pipeline_level);
        return 2 * pipeline_level;
    endfunction

    // Occupancy counter width; must be able to hold DEPTH itself.
    function automatic int count_width(input int depth);
        return $clog2(depth + 1);
    endfunction

    // Buffer pointer width; never narrower than one bit.
    function automatic int ptr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/rs_sink_fifo_mem.sv
// Simple dual-port storage for the sink FIFO. The read side registers the
// word at the head pointer's next value, so the head is visible right after
// the edge that moves it (show-ahead). A write landing on that same slot is
// forwarded so a word written into an empty queue shows up one edge later.
module rs_sink_fifo_mem #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 16,
    parameter int PTR_WIDTH  = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr_en,
    input  logic [PTR_WIDTH-1:0]  wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_load,
    input  logic [PTR_WIDTH-1:0]  rd_addr_next,
    output logic [DATA_WIDTH-1:0] rd_data
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // Storage array: synchronous write, no reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Head register: load the word the read pointer will point at after this edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_data <= '0;
        end else if (rd_load) begin
            if (wr_en && (wr_addr == rd_addr_next)) begin
                rd_data <= wr_data;
            end else begin
                rd_data <= mem[rd_addr_next];
            end
        end
    end

endmodule

// File: rtl/rs_pipeline_sink_fifo.sv
// Receive end of a feed-forward pipelined stream link. Absorbs every word
// still in flight after credit is withdrawn and returns a registered credit
// (if_full_n) that the upstream sees through its own backward pipeline.
module rs_pipeline_sink_fifo
    import rs_pipeline_sink_fifo_pkg::*;
#(
    parameter int    DATA_WIDTH     = 32,
    parameter int    PIPELINE_LEVEL = 2,
    parameter int    DEPTH          = 16,
    parameter string __REGION       = ""
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [DATA_WIDTH-1:0]         if_din,
    input  logic                          if_write,
    output logic                          if_full_n,
    output logic [DATA_WIDTH-1:0]         if_dout,
    output logic                          if_empty_n,
    input  logic                          if_read,
    output logic [count_width(DEPTH)-1:0] if_count,
    output logic                          if_overflow
);

    localparam int HEADROOM = headroom(PIPELINE_LEVEL);
    localparam int CW       = count_width(DEPTH);
    localparam int PW       = ptr_width(DEPTH);

    // Without room for the headroom plus one word the credit could never rise.
    if (DEPTH <= 2 * PIPELINE_LEVEL + 1) begin : g_bad_depth
        $error("rs_pipeline_sink_fifo %s: DEPTH %0d too small for PIPELINE_LEVEL %0d",
               __REGION, DEPTH, PIPELINE_LEVEL);
    end

    logic [PW-1:0] wr_ptr, wr_ptr_nxt;
    logic [PW-1:0] rd_ptr, rd_ptr_nxt;
    logic [CW-1:0] count, count_nxt;
    logic          rd_eff, wr_eff, wr_drop;

    // Pointers wrap explicitly so DEPTH need not be a power of two.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Effective read/write and next-state arithmetic; a read frees the slot a
    // same-cycle write needs when the buffer is full.
    always_comb begin
        rd_eff     = if_read && (count != '0);
        wr_eff     = if_write && ((count != CW'(DEPTH)) || rd_eff);
        wr_drop    = if_write && !wr_eff;
        wr_ptr_nxt = wr_eff ? ptr_inc(wr_ptr) : wr_ptr;
        rd_ptr_nxt = rd_eff ? ptr_inc(rd_ptr) : rd_ptr;
        count_nxt  = count;
        if (wr_eff && !rd_eff) begin
            count_nxt = count + 1'b1;
        end else if (rd_eff && !wr_eff) begin
            count_nxt = count - 1'b1;
        end
    end

    // Pointer, occupancy, credit and sticky overflow state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            if_full_n   <= 1'b0;
            if_overflow <= 1'b0;
        end else begin
            wr_ptr      <= wr_ptr_nxt;
            rd_ptr      <= rd_ptr_nxt;
            count       <= count_nxt;
            if_full_n   <= (count_nxt < CW'(DEPTH - HEADROOM));
            if (wr_drop) begin
                if_overflow <= 1'b1;
            end
        end
    end

    assign if_empty_n = (count != '0);
    assign if_count   = count;

    // Head register holds its last value while the queue is empty.
    rs_sink_fifo_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .PTR_WIDTH  (PW)
    ) u_mem (
        .clk          (clk),
        .reset        (reset),
        .wr_en        (wr_eff),
        .wr_addr      (wr_ptr),
        .wr_data      (if_din),
        .rd_load      (count_nxt != '0),
        .rd_addr_next (rd_ptr_nxt),
        .rd_data      (if_dout)
    );

endmodule

// File: tb/tb_rs_pipeline_sink_fifo.sv
// Bench for rs_pipeline_sink_fifo: instance 0 is DEPTH=16/PL=2 driven by
// directed sequences, instance 1 is DEPTH=10/PL=1 fed by an emulated
// pipelined upstream with random stalls. Each instance has a queue model.
module tb_rs_pipeline_sink_fifo;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int passes = 0;

    logic        a_rst = 1'b1, a_wr = 1'b0, a_rd = 1'b0;
    logic [31:0] a_din = '0;
    logic        b_rst = 1'b1, b_wr = 1'b0, b_rd = 1'b0;
    logic [31:0] b_din = '0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    endtask

    for (genvar g = 0; g < 2; g++) begin : g_inst
        localparam int D  = (g == 0) ? 16 : 10;
        localparam int PL = (g == 0) ? 2 : 1;
        localparam int CW = $clog2(D + 1);

        logic          rst, wr, rd, full_n, empty_n, ovf;
        logic [31:0]   din, dout;
        logic [CW-1:0] cnt;

        assign rst = (g == 0) ? a_rst : b_rst;
        assign wr  = (g == 0) ? a_wr  : b_wr;
        assign rd  = (g == 0) ? a_rd  : b_rd;
        assign din = (g == 0) ? a_din : b_din;

        rs_pipeline_sink_fifo #(
            .DATA_WIDTH     (32),
            .PIPELINE_LEVEL (PL),
            .DEPTH          (D)
        ) u_dut (
            .clk         (clk),
            .reset       (rst),
            .if_din      (din),
            .if_write    (wr),
            .if_full_n   (full_n),
            .if_dout     (dout),
            .if_empty_n  (empty_n),
            .if_read     (rd),
            .if_count    (cnt),
            .if_overflow (ovf)
        );

        bit          s_wr = 1'b0, s_rd = 1'b0;
        logic [31:0] s_din = '0;
        always @(posedge clk) begin
            s_wr  <= wr;
            s_rd  <= rd;
            s_din <= din;
        end

        logic [31:0] mq[$];
        bit          m_ovf, m_full_n;

        initial begin
            forever begin
                @(negedge clk);
                if (rst) begin
                    mq.delete();
                    m_ovf    = 1'b0;
                    m_full_n = 1'b0;
                end else begin
                    if (s_rd && mq.size() > 0) void'(mq.pop_front());
                    if (s_wr) begin
                        if (mq.size() < D) mq.push_back(s_din);
                        else m_ovf = 1'b1;
                    end
                    m_full_n = (mq.size() < D - 2 * PL);
                end
                chk($sformatf("i%0d count", g), 32'(cnt), 32'(mq.size()));
                chk($sformatf("i%0d empty_n", g), 32'(empty_n), 32'(mq.size() > 0));
                chk($sformatf("i%0d overflow", g), 32'(ovf), 32'(m_ovf));
                chk($sformatf("i%0d full_n", g), 32'(full_n), 32'(m_full_n));
                if (rst) chk($sformatf("i%0d reset dout", g), dout, 32'h0);
                else if (mq.size() > 0) chk($sformatf("i%0d dout", g), dout, mq[0]);
            end
        end
    end

    task automatic tick(input bit w, input logic [31:0] d, input bit r);
        @(negedge clk);
        a_wr = w; a_din = d; a_rd = r;
        @(posedge clk);
        #1;
        a_wr = 1'b0; a_rd = 1'b0;
    endtask

    task automatic run_a();
        logic [31:0] last, first;
        repeat (2) @(negedge clk);
        #1;
        chk("a reset full_n", 32'(g_inst[0].full_n), 32'd0);
        chk("a reset count", 32'(g_inst[0].cnt), 32'd0);
        #1 a_rst = 1'b0;
        #1 chk("a full_n before first edge", 32'(g_inst[0].full_n), 32'd0);
        @(posedge clk); #1;
        chk("a full_n after release", 32'(g_inst[0].full_n), 32'd1);

        // basic order with continuous reads
        tick(1'b1, 32'h11, 1'b1);
        chk("basic dout0", g_inst[0].dout, 32'h11);
        chk("basic count0", 32'(g_inst[0].cnt), 32'd1);
        tick(1'b1, 32'h22, 1'b1);
        chk("basic dout1", g_inst[0].dout, 32'h22);
        chk("basic count1", 32'(g_inst[0].cnt), 32'd1);
        tick(1'b1, 32'h33, 1'b1);
        chk("basic dout2", g_inst[0].dout, 32'h33);
        tick(1'b0, 32'h0, 1'b1);
        chk("basic drained", 32'(g_inst[0].empty_n), 32'd0);

        // credit threshold: 12 words drop the credit, 4 more fit
        for (int i = 0; i < 16; i++) begin
            tick(1'b1, 32'h100 + 32'(i), 1'b0);
            if (i == 10) chk("credit at 11", 32'(g_inst[0].full_n), 32'd1);
            if (i == 11) chk("credit at 12", 32'(g_inst[0].full_n), 32'd0);
        end
        chk("headroom count", 32'(g_inst[0].cnt), 32'd16);
        chk("headroom overflow", 32'(g_inst[0].ovf), 32'd0);

        // simultaneous read and write at full
        tick(1'b1, 32'hAB, 1'b1);
        chk("simul count", 32'(g_inst[0].cnt), 32'd16);
        chk("simul overflow", 32'(g_inst[0].ovf), 32'd0);
        first = g_inst[0].dout;
        chk("simul head", first, 32'h101);
        last = '0;
        for (int i = 0; i < 16; i++) begin
            last = g_inst[0].dout;
            tick(1'b0, 32'h0, 1'b1);
            if (i == 3) chk("credit at 12 draining", 32'(g_inst[0].full_n), 32'd0);
            if (i == 4) chk("credit at 11 draining", 32'(g_inst[0].full_n), 32'd1);
        end
        chk("simul last word", last, 32'hAB);
        chk("simul empty", 32'(g_inst[0].cnt), 32'd0);

        // overflow: extra write at full with no read is dropped
        for (int i = 0; i < 16; i++) tick(1'b1, 32'h200 + 32'(i), 1'b0);
        tick(1'b1, 32'hDEAD, 1'b0);
        chk("ovf count", 32'(g_inst[0].cnt), 32'd16);
        chk("ovf flag", 32'(g_inst[0].ovf), 32'd1);
        chk("ovf head", g_inst[0].dout, 32'h200);
        tick(1'b0, 32'h0, 1'b0);
        chk("ovf sticky", 32'(g_inst[0].ovf), 32'd1);
        for (int i = 0; i < 11; i++) tick(1'b0, 32'h0, 1'b1);
        chk("pre-reset count", 32'(g_inst[0].cnt), 32'd5);
        chk("pre-reset head", g_inst[0].dout, 32'h20B);

        // asynchronous reset in the middle of traffic
        @(negedge clk);
        a_wr = 1'b1; a_din = 32'hEE; a_rd = 1'b1;
        #2 a_rst = 1'b1;
        #1;
        chk("async count", 32'(g_inst[0].cnt), 32'd0);
        chk("async empty_n", 32'(g_inst[0].empty_n), 32'd0);
        chk("async overflow", 32'(g_inst[0].ovf), 32'd0);
        chk("async full_n", 32'(g_inst[0].full_n), 32'd0);
        chk("async dout", g_inst[0].dout, 32'h0);
        a_wr = 1'b0; a_rd = 1'b0;
        repeat (2) @(negedge clk);
        #2 a_rst = 1'b0;
        @(posedge clk); #1;
        chk("release full_n", 32'(g_inst[0].full_n), 32'd1);
        tick(1'b1, 32'h77, 1'b0);
        chk("post-reset write", g_inst[0].dout, 32'h77);
        chk("post-reset count", 32'(g_inst[0].cnt), 32'd1);
    endtask

    task automatic run_b();
        bit          inf_v[$];
        logic [31:0] inf_d[$];
        bit          hist[$];
        bit          seen, send;
        int          sent, got;
        sent = 0; got = 0;
        for (int i = 0; i < 1; i++) begin
            inf_v.push_back(1'b0);
            inf_d.push_back(32'h0);
            hist.push_back(1'b0);
        end
        repeat (3) @(negedge clk);
        #2 b_rst = 1'b0;
        for (int cyc = 0; cyc < 3000 && got < 100; cyc++) begin
            @(negedge clk);
            hist.push_back(g_inst[1].full_n);
            seen = hist.pop_front();
            send = seen && (sent < 100) && ($urandom_range(0, 3) != 0);
            inf_v.push_back(send);
            inf_d.push_back(send ? 32'h1000 + 32'(sent) : 32'h0);
            if (send) sent++;
            b_wr  = inf_v.pop_front();
            b_din = inf_d.pop_front();
            b_rd  = ($urandom_range(0, 2) != 0);
            if (b_rd && g_inst[1].empty_n) begin
                chk("stream word", g_inst[1].dout, 32'h1000 + 32'(got));
                got++;
            end
        end
        @(negedge clk);
        b_wr = 1'b0; b_rd = 1'b0;
        chk("stream all received", 32'(got), 32'd100);
        chk("stream no overflow", 32'(g_inst[1].ovf), 32'd0);
    endtask

    initial begin
        fork
            run_a();
            run_b();
        join
        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d so far", passes, checks);
        $fatal(1, "timeout");
    end

endmodule
